// File: rtl/pc_check_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_check_pkg
// Brief    : Shared types and constants for the next-PC prediction checker.
// Revision : 1.0 - initial release
// ============================================================================
package pc_check_pkg;

  localparam int unsigned DEF_XLEN   = 64;
  localparam int unsigned INSN_BYTES = 4;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    SQUASH = 2'd1,
    CHECK  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pc_fifo
// Brief    : Synchronous FIFO buffering retired PCs; head is read combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fifo #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic [XLEN-1:0] i_wdata,
  input  logic            i_pop,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_full,
  output logic            o_empty
);

  localparam int unsigned c_aw = $clog2(DEPTH);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [c_aw:0]   r_wptr;
  logic [c_aw:0]   r_rptr;
  logic            w_do_push;
  logic            w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                     (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr[c_aw-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[c_aw-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_checker.sv
`default_nettype none
// ============================================================================
// Module   : pc_checker
// Brief    : Compares retired-PC trace against predictor output, redirects on
//            mismatch or loss of sync, and keeps saturating statistics.
// Revision : 1.0 - initial release
// ============================================================================
module pc_checker
  import pc_check_pkg::*;
#(
  parameter int unsigned XLEN       = DEF_XLEN,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PRED_LAT   = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             act_valid,
  input  logic [XLEN-1:0]  act_pc,
  output logic             act_ready,
  input  logic [XLEN-1:0]  pc_pre,
  output logic             miss,
  output logic [XLEN-1:0]  pc_curr,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] mis_cnt,
  output logic [CNT_W-1:0] sync_cnt
);

  localparam int unsigned         c_sq_w    = $clog2(PRED_LAT + 1);
  localparam logic [c_sq_w-1:0]   c_sq_load = c_sq_w'(PRED_LAT);
  localparam logic [c_sq_w-1:0]   c_sq_last = c_sq_w'(1);

  state_t            r_state;
  logic [c_sq_w-1:0] r_sq;
  logic              r_miss;
  logic [XLEN-1:0]   r_pc_curr;
  logic [CNT_W-1:0]  r_hit;
  logic [CNT_W-1:0]  r_mis;
  logic [CNT_W-1:0]  r_sync;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic [XLEN-1:0]   w_head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign act_ready = !w_full;
  assign w_pop     = !w_empty && ((r_state == SYNC) || (r_state == CHECK));

  pc_fifo #(
    .XLEN  (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (act_valid),
    .i_wdata (act_pc),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= SYNC;
      r_sq      <= '0;
      r_miss    <= 1'b0;
      r_pc_curr <= '0;
      r_hit     <= '0;
      r_mis     <= '0;
      r_sync    <= '0;
    end else begin
      r_miss <= 1'b0;
      unique case (r_state)
        SYNC: begin
          if (!w_empty) begin
            r_miss    <= 1'b1;
            r_pc_curr <= w_head;
            r_sync    <= sat_inc(r_sync);
            r_sq      <= c_sq_load;
            r_state   <= SQUASH;
          end
        end
        SQUASH: begin
          // The cycle carrying miss is the first of PRED_LAT discarded slots.
          r_sq <= r_sq - 1'b1;
          if (r_sq == c_sq_last) begin
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (w_empty) begin
            r_state <= SYNC;
          end else if (w_head == pc_pre) begin
            r_hit <= sat_inc(r_hit);
          end else begin
            r_mis     <= sat_inc(r_mis);
            r_miss    <= 1'b1;
            r_pc_curr <= w_head;
            r_sq      <= c_sq_load;
            r_state   <= SQUASH;
          end
        end
        default: begin
          r_state <= SYNC;
        end
      endcase
    end
  end

  assign miss     = r_miss;
  assign pc_curr  = r_pc_curr;
  assign hit_cnt  = r_hit;
  assign mis_cnt  = r_mis;
  assign sync_cnt = r_sync;

endmodule
`default_nettype wire

// File: tb/tb_pc_checker.sv
`default_nettype none
// Bench for pc_checker: queue-based reference model plus a predictor that
// follows the redirect contract, directed scenarios and a randomized trace.
module tb_pc_checker;
  import pc_check_pkg::*;

  localparam int XLEN  = 64;
  localparam int DEPTH = 8;
  localparam int LAT   = 4;
  localparam int CW    = 5;
  localparam int CMAX  = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            act_valid = 1'b0;
  logic [XLEN-1:0] act_pc = '0;
  logic [XLEN-1:0] pc_pre = '0;
  logic            act_ready;
  logic            miss;
  logic [XLEN-1:0] pc_curr;
  logic [CW-1:0]   hit_cnt;
  logic [CW-1:0]   mis_cnt;
  logic [CW-1:0]   sync_cnt;

  pc_checker #(
    .XLEN(XLEN), .FIFO_DEPTH(DEPTH), .PRED_LAT(LAT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .act_valid(act_valid), .act_pc(act_pc),
    .act_ready(act_ready), .pc_pre(pc_pre), .miss(miss), .pc_curr(pc_curr),
    .hit_cnt(hit_cnt), .mis_cnt(mis_cnt), .sync_cnt(sync_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: queue of retired PCs, redirect/discard bookkeeping.
  logic [XLEN-1:0] mq[$];
  int              m_discard = 0;
  bit              m_locked  = 1'b0;
  bit              m_miss    = 1'b0;
  logic [XLEN-1:0] m_pc_curr = '0;
  int              m_hit = 0, m_mis = 0, m_sync = 0;
  bit              m_valid = 1'b0;

  always @(posedge clk) begin
    logic [XLEN-1:0] h;
    bit room;
    if (rst) begin
      mq.delete();
      m_discard = 0;
      m_locked  = 1'b0;
      m_miss    = 1'b0;
      m_pc_curr = '0;
      m_hit = 0; m_mis = 0; m_sync = 0;
      m_valid = 1'b1;
    end else begin
      room   = (mq.size() < DEPTH);
      m_miss = 1'b0;
      if (m_discard > 0) begin
        m_discard--;
      end else if (mq.size() == 0) begin
        m_locked = 1'b0;
      end else begin
        h = mq.pop_front();
        if (!m_locked || h != pc_pre) begin
          if (!m_locked) m_sync = (m_sync < CMAX) ? m_sync + 1 : m_sync;
          else           m_mis  = (m_mis  < CMAX) ? m_mis  + 1 : m_mis;
          m_miss    = 1'b1;
          m_pc_curr = h;
          m_discard = LAT;
          m_locked  = 1'b1;
        end else begin
          m_hit = (m_hit < CMAX) ? m_hit + 1 : m_hit;
        end
      end
      if (act_valid && room) mq.push_back(act_pc);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("miss",      miss,      m_miss);
      check("pc_curr",   pc_curr,   m_pc_curr);
      check("hit_cnt",   hit_cnt,   m_hit);
      check("mis_cnt",   mis_cnt,   m_mis);
      check("sync_cnt",  sync_cnt,  m_sync);
      check("act_ready", act_ready, mq.size() < DEPTH);
    end
  end

  // Predictor: junk for LAT cycles from the miss cycle, then X+4, X+8, ...
  int              p_wait = 0;
  logic [XLEN-1:0] p_tgt  = '0;
  always @(negedge clk) begin
    if (miss) begin
      p_wait = LAT;
      p_tgt  = pc_curr + INSN_BYTES;
      pc_pre = {$urandom, $urandom};
    end else if (p_wait > 1) begin
      p_wait--;
      pc_pre = {$urandom, $urandom};
    end else if (p_wait == 1) begin
      p_wait = 0;
      pc_pre = p_tgt;
    end else begin
      pc_pre = pc_pre + INSN_BYTES;
    end
  end

  bit saw_full = 1'b0;
  always @(negedge clk) if (!rst && !act_ready) saw_full = 1'b1;

  task automatic do_reset(input int n);
    rst = 1'b1;
    act_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    act_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Offer one PC, hold it until accepted; returns at the negedge after the push.
  task automatic push_pc(input logic [XLEN-1:0] pc);
    int guard;
    guard = 0;
    act_valid = 1'b1;
    act_pc    = pc;
    while (!act_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL push_timeout: act_ready stuck low, got 0 expected 1");
        act_valid = 1'b0;
        return;
      end
    end
    @(negedge clk);
    act_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] tr3 [6];
    logic [XLEN-1:0] pc;
    int r;
    tr3 = '{64'h1000, 64'h1004, 64'h2000, 64'h2004, 64'h2008, 64'h200c};

    // 1: reset state, single push -> sync redirect
    do_reset(3);
    check("rst_miss",      miss,      0);
    check("rst_pc_curr",   pc_curr,   0);
    check("rst_hit",       hit_cnt,   0);
    check("rst_ready",     act_ready, 1);
    push_pc(64'h1000);
    @(negedge clk);
    check("t1_miss",    miss,     1);
    check("t1_pc_curr", pc_curr,  64'h1000);
    check("t1_sync",    sync_cnt, 1);
    @(negedge clk);
    check("t1_miss_low", miss, 0);
    idle(10);

    // 2: sequential trace, all predicted
    do_reset(2);
    for (int i = 0; i <= 16; i++) push_pc(64'h1000 + 4 * i);
    idle(20);
    check("t2_hit",  hit_cnt,  16);
    check("t2_mis",  mis_cnt,  0);
    check("t2_sync", sync_cnt, 1);

    // 3: taken branch causes one redirect
    do_reset(2);
    for (int i = 0; i < 6; i++) push_pc(tr3[i]);
    idle(20);
    check("t3_mis",     mis_cnt, 1);
    check("t3_hit",     hit_cnt, 4);
    check("t3_pc_curr", pc_curr, 64'h2000);

    // 4: trace ran dry -> resync on the next PC
    push_pc(64'h3000);
    @(negedge clk);
    check("t4_miss",    miss,     1);
    check("t4_pc_curr", pc_curr,  64'h3000);
    check("t4_sync",    sync_cnt, 2);
    idle(10);

    // 5: every entry mispredicts, backlog fills the buffer
    do_reset(2);
    saw_full = 1'b0;
    for (int k = 1; k <= 13; k++) push_pc(64'h4000 * k);
    idle(40);
    check("t5_full_seen", saw_full, 1);
    check("t5_mis",       mis_cnt,  12);
    check("t5_sync",      sync_cnt, 1);
    check("t5_hit",       hit_cnt,  0);

    // 6: reset in the middle of a squash with 5 entries buffered
    do_reset(2);
    for (int k = 1; k <= 7; k++) push_pc(64'h6000 * k);
    check("t6_miss_pre", miss,    1);
    check("t6_mis_pre",  mis_cnt, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_miss",  miss,      0);
    check("t6_hit",   hit_cnt,   0);
    check("t6_mis",   mis_cnt,   0);
    check("t6_sync",  sync_cnt,  0);
    check("t6_ready", act_ready, 1);
    rst = 1'b0;
    idle(5);

    // Randomized trace: jumps, upper-half-only jumps, gaps, occasional reset
    pc = 64'h0000_8000_0001_0000;
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3)        pc = {$urandom, $urandom} & ~64'h3;
      else if (r < 6)   pc = pc ^ (64'h1 << $urandom_range(32, 63));
      else if (r < 10)  idle($urandom_range(1, 8));
      else if (r == 10) begin
        rst = 1'b1;
        act_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
      end
      push_pc(pc);
      pc = pc + INSN_BYTES;
    end
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
